// File: rtl/data_memory_mmio.sv
// data_memory_mmio
// Data memory with a small memory-mapped device block.
//   Address[30]=0 : RAM of RAM_WORDS 32-bit words (little-endian, aliased)
//   Address[30]=1 : devices
//     0x4000_0000 TH       timer reload value
//     0x4000_0004 TL       timer counter (counts up, reloads from TH)
//     0x4000_0008 TCON     [0] run, [1] irq enable, [2] irq pending
//     0x4000_000C LED      LED register (low LED_WIDTH bits drive LED_out)
//     0x4000_0010 BCD      BCD register (low BCD_WIDTH bits drive BCD_out)
//     0x4000_0014 SYSTICK  free-running cycle counter, read-only
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   MemRead, MemWrite   access strobes
//   MemSize, MemSigned  00 byte / 01 half / 1x word; sign-extend sub-word loads
//   Address, Write_data byte address, right-aligned store data
//   Read_data           combinational load data (0 when idle or misaligned)
//   BCD_out, LED_out    display register outputs
//   irq                 TCON[2]
//   misaligned          combinational access-error flag
module data_memory_mmio #(
  parameter int RAM_WORDS = 512,
  parameter int BCD_WIDTH = 12,
  parameter int LED_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic [1:0]           MemSize,
  input  logic                 MemSigned,
  input  logic [31:0]          Address,
  input  logic [31:0]          Write_data,
  output logic [31:0]          Read_data,
  output logic [BCD_WIDTH-1:0] BCD_out,
  output logic [LED_WIDTH-1:0] LED_out,
  output logic                 irq,
  output logic                 misaligned
);

  localparam int AW = $clog2(RAM_WORDS);

  localparam logic [27:0] OFF_TH      = 28'd0;
  localparam logic [27:0] OFF_TL      = 28'd1;
  localparam logic [27:0] OFF_TCON    = 28'd2;
  localparam logic [27:0] OFF_LED     = 28'd3;
  localparam logic [27:0] OFF_BCD     = 28'd4;
  localparam logic [27:0] OFF_SYSTICK = 28'd5;

  function automatic logic [31:0] seg_code(input int i);
    case (i)
      0:  return 32'h3F;
      1:  return 32'h06;
      2:  return 32'h5B;
      3:  return 32'h4F;
      4:  return 32'h66;
      5:  return 32'h6D;
      6:  return 32'h7D;
      7:  return 32'h07;
      8:  return 32'h7F;
      9:  return 32'h6F;
      10: return 32'h77;
      11: return 32'h7C;
      12: return 32'h39;
      13: return 32'h5E;
      14: return 32'h79;
      15: return 32'h71;
      default: return 32'h0;
    endcase
  endfunction

  logic [31:0]   ram_q [RAM_WORDS];
  logic [31:0]   th_q, th_d;
  logic [31:0]   tl_q, tl_d;
  logic [2:0]    tcon_q, tcon_d;
  logic [31:0]   led_q, led_d;
  logic [31:0]   bcd_q, bcd_d;
  logic [31:0]   systick_q, systick_d;

  logic          is_dev;
  logic          size_half;
  logic          size_word;
  logic          wr_en;
  logic          ram_we;
  logic [AW-1:0] ram_idx;
  logic [27:0]   dev_off;
  logic [31:0]   ram_word;
  logic [3:0]    wbe;
  logic [31:0]   wdat;
  logic [31:0]   bitmask;
  logic [31:0]   wmerge;
  logic [31:0]   dev_rd;
  logic [31:0]   rd_word;
  logic [7:0]    lane8;
  logic [15:0]   lane16;
  logic          unused_addr;

  // Bit 31 plays no part in decode; everything above the RAM index aliases.
  assign unused_addr = Address[31];

  assign is_dev    = Address[30];
  assign size_half = (MemSize == 2'b01);
  assign size_word = MemSize[1];
  assign dev_off   = Address[29:2];
  assign ram_idx   = Address[AW+1:2];
  assign ram_word  = ram_q[ram_idx];

  // Devices only accept full-word accesses.
  assign misaligned = (MemRead | MemWrite) &
                      ((size_half & Address[0]) |
                       (size_word & (Address[1:0] != 2'b00)) |
                       (is_dev & ~size_word));

  assign wr_en  = MemWrite & ~misaligned;
  assign ram_we = wr_en & ~is_dev;

  // Replicate store data across all lanes; the byte enables pick the lane.
  always_comb begin
    wbe  = 4'b1111;
    wdat = Write_data;
    case (MemSize)
      2'b00: begin
        wbe  = 4'b0001 << Address[1:0];
        wdat = {4{Write_data[7:0]}};
      end
      2'b01: begin
        wbe  = Address[1] ? 4'b1100 : 4'b0011;
        wdat = {2{Write_data[15:0]}};
      end
      default: begin
        wbe  = 4'b1111;
        wdat = Write_data;
      end
    endcase
  end

  assign bitmask = {{8{wbe[3]}}, {8{wbe[2]}}, {8{wbe[1]}}, {8{wbe[0]}}};
  assign wmerge  = (ram_word & ~bitmask) | (wdat & bitmask);

  // One register per word so reset can preload the 7-segment table.
  for (genvar w = 0; w < RAM_WORDS; w++) begin : g_ram
    localparam logic [31:0] INIT = seg_code(w);
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        ram_q[w] <= INIT;
      end else if (ram_we && (ram_idx == AW'(w))) begin
        ram_q[w] <= wmerge;
      end
    end
  end

  always_comb begin
    th_d      = th_q;
    tl_d      = tl_q;
    tcon_d    = tcon_q;
    led_d     = led_q;
    bcd_d     = bcd_q;
    systick_d = systick_q + 32'd1;

    if (tcon_q[0]) begin
      if (tl_q == 32'hFFFF_FFFF) begin
        tl_d = th_q;
        if (tcon_q[1]) tcon_d[2] = 1'b1;
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end

    // A CPU store to TL cancels the whole timer update for this cycle,
    // including an overflow that would otherwise set the pending flag.
    if (wr_en && is_dev) begin
      case (dev_off)
        OFF_TH:   th_d = Write_data;
        OFF_TL: begin
          tl_d   = Write_data;
          tcon_d = tcon_q;
        end
        OFF_TCON: tcon_d = Write_data[2:0];
        OFF_LED:  led_d  = Write_data;
        OFF_BCD:  bcd_d  = Write_data;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q      <= '0;
      tl_q      <= '0;
      tcon_q    <= '0;
      led_q     <= '0;
      bcd_q     <= '0;
      systick_q <= '0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      led_q     <= led_d;
      bcd_q     <= bcd_d;
      systick_q <= systick_d;
    end
  end

  always_comb begin
    dev_rd = 32'h0;
    case (dev_off)
      OFF_TH:      dev_rd = th_q;
      OFF_TL:      dev_rd = tl_q;
      OFF_TCON:    dev_rd = {29'h0, tcon_q};
      OFF_LED:     dev_rd = led_q;
      OFF_BCD:     dev_rd = bcd_q;
      OFF_SYSTICK: dev_rd = systick_q;
      default:     dev_rd = 32'h0;
    endcase
  end

  always_comb begin
    rd_word   = is_dev ? dev_rd : ram_word;
    lane8     = rd_word[{Address[1:0], 3'b000} +: 8];
    lane16    = Address[1] ? rd_word[31:16] : rd_word[15:0];
    Read_data = 32'h0;
    if (MemRead && !misaligned) begin
      case (MemSize)
        2'b00:   Read_data = {{24{MemSigned & lane8[7]}}, lane8};
        2'b01:   Read_data = {{16{MemSigned & lane16[15]}}, lane16};
        default: Read_data = rd_word;
      endcase
    end
  end

  assign irq     = tcon_q[2];
  assign BCD_out = bcd_q[BCD_WIDTH-1:0];
  assign LED_out = led_q[LED_WIDTH-1:0];

endmodule

// File: tb/tb_data_memory_mmio.sv
module tb_data_memory_mmio;
  localparam int RW = 512;
  localparam int BW = 12;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          MemRead = 1'b0;
  logic          MemWrite = 1'b0;
  logic [1:0]    MemSize = 2'b10;
  logic          MemSigned = 1'b0;
  logic [31:0]   Address = 32'h0;
  logic [31:0]   Write_data = 32'h0;
  logic [31:0]   Read_data;
  logic [BW-1:0] BCD_out;
  logic [LW-1:0] LED_out;
  logic          irq;
  logic          misaligned;

  always #5 clk = ~clk;

  data_memory_mmio #(.RAM_WORDS(RW), .BCD_WIDTH(BW), .LED_WIDTH(LW)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemSize(MemSize), .MemSigned(MemSigned), .Address(Address),
    .Write_data(Write_data), .Read_data(Read_data), .BCD_out(BCD_out),
    .LED_out(LED_out), .irq(irq), .misaligned(misaligned)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: byte-addressed memory plus device registers.
  logic [7:0]  m_mem [4*RW];
  logic [7:0]  SEG [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                            8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  logic [31:0] m_th, m_tl, m_led, m_bcd, m_sys;
  logic [2:0]  m_tcon;
  logic [31:0] last_rd;
  logic        last_mis;

  function automatic void m_reset();
    for (int i = 0; i < 4*RW; i++) m_mem[i] = 8'h00;
    for (int k = 0; k < 16; k++) m_mem[4*k] = SEG[k];
    m_th = 0; m_tl = 0; m_led = 0; m_bcd = 0; m_sys = 0; m_tcon = 0;
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    if (sz == 2'b00) return 1;
    if (sz == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic m_mis(input logic rd, input logic wr, input logic [1:0] sz,
                                 input logic [31:0] a);
    if (!(rd || wr)) return 1'b0;
    if (a[30] && nbytes(sz) != 4) return 1'b1;
    if ((a % nbytes(sz)) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input logic rd, input logic [1:0] sz, input logic sg,
                                         input logic [31:0] a);
    logic [31:0] v;
    int base;
    int n;
    if (!rd || m_mis(rd, 1'b0, sz, a)) return 32'h0;
    if (a[30]) begin
      case (a & 32'h3FFF_FFFF)
        32'h00: return m_th;
        32'h04: return m_tl;
        32'h08: return {29'h0, m_tcon};
        32'h0C: return m_led;
        32'h10: return m_bcd;
        32'h14: return m_sys;
        default: return 32'h0;
      endcase
    end
    n = nbytes(sz);
    base = int'(a % (4*RW));
    v = 32'h0;
    for (int k = 0; k < n; k++) v = v | (32'(m_mem[base+k]) << (8*k));
    if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  function automatic void m_step(input logic rd, input logic wr, input logic [1:0] sz,
                                 input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] n_tl;
    logic [2:0]  n_tcon;
    int base;
    n_tl = m_tl;
    n_tcon = m_tcon;
    if (m_tcon[0]) begin
      if (m_tl == 32'hFFFF_FFFF) begin
        n_tl = m_th;
        if (m_tcon[1]) n_tcon[2] = 1'b1;
      end else begin
        n_tl = m_tl + 1;
      end
    end
    if (wr && !m_mis(rd, wr, sz, a)) begin
      if (a[30]) begin
        case (a & 32'h3FFF_FFFF)
          32'h00: m_th = wd;
          32'h04: begin n_tl = wd; n_tcon = m_tcon; end
          32'h08: n_tcon = wd[2:0];
          32'h0C: m_led = wd;
          32'h10: m_bcd = wd;
          default: ;
        endcase
      end else begin
        base = int'(a % (4*RW));
        for (int k = 0; k < nbytes(sz); k++) m_mem[base+k] = wd[8*k +: 8];
      end
    end
    m_tl = n_tl;
    m_tcon = n_tcon;
    m_sys = m_sys + 1;
  endfunction

  task automatic chk(input logic [31:0] got, input logic [31:0] exp, input string tag);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One bus cycle: starts just after a falling edge, ends at the next one.
  task automatic cyc(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd);
    MemRead = rd; MemWrite = wr; MemSize = sz; MemSigned = sg;
    Address = a; Write_data = wd;
    #1;
    chk({31'h0, misaligned}, {31'h0, m_mis(rd, wr, sz, a)}, "misaligned");
    chk(Read_data, m_read(rd, sz, sg, a), "read_data");
    last_rd = Read_data;
    last_mis = misaligned;
    @(posedge clk);
    m_step(rd, wr, sz, a, wd);
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;
    chk({31'h0, irq}, {31'h0, m_tcon[2]}, "irq");
    chk(32'(BCD_out), 32'(m_bcd[BW-1:0]), "bcd_out");
    chk(32'(LED_out), 32'(m_led[LW-1:0]), "led_out");
  endtask

  task automatic wr32(input logic [31:0] a, input logic [31:0] wd);
    cyc(1'b0, 1'b1, 2'b10, 1'b0, a, wd);
  endtask

  task automatic rd32(input logic [31:0] a);
    cyc(1'b1, 1'b0, 2'b10, 1'b0, a, 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    chk({31'h0, irq}, 32'h0, "reset_irq");
    chk(32'(BCD_out), 32'h0, "reset_bcd");
    chk(32'(LED_out), 32'h0, "reset_led");
    @(negedge clk);
    reset = 1'b0;

    rd32(32'h0000_0008);     chk(last_rd, 32'h0000_005B, "seg_word2");
    rd32(32'h4000_0010);     chk(last_rd, 32'h0, "bcd_after_reset");
    rd32(32'h4000_0014);

    wr32(32'h0000_0100, 32'h1122_3344);
    cyc(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0102, 32'h0000_00AA);
    rd32(32'h0000_0100);     chk(last_rd, 32'h11AA_3344, "byte_merge");
    cyc(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0102, 32'h0);
    chk(last_rd, 32'hFFFF_FFAA, "byte_signed");
    cyc(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0102, 32'h0);
    chk(last_rd, 32'h0000_00AA, "byte_unsigned");

    cyc(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0101, 32'h0000_BEEF);
    chk({31'h0, last_mis}, 32'h1, "half_wr_misaligned");
    cyc(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0101, 32'h0);
    chk(last_rd, 32'h0, "half_rd_misaligned_zero");
    rd32(32'h0000_0100);     chk(last_rd, 32'h11AA_3344, "ram_unchanged");

    wr32(32'h4000_0010, 32'h0000_0ABC);
    chk(32'(BCD_out), 32'h0ABC, "bcd_write");
    cyc(1'b0, 1'b1, 2'b00, 1'b0, 32'h4000_0010, 32'h0000_0055);
    chk({31'h0, last_mis}, 32'h1, "dev_byte_misaligned");
    chk(32'(BCD_out), 32'h0ABC, "bcd_unchanged");
    wr32(32'h4000_000C, 32'h0000_01FF);
    chk(32'(LED_out), 32'h00FF, "led_low_bits");
    rd32(32'h4000_000C);     chk(last_rd, 32'h0000_01FF, "led_readback");
    rd32(32'h4000_0018);     chk(last_rd, 32'h0, "unmapped_read");

    wr32(32'h4000_0000, 32'hFFFF_FFFD);
    wr32(32'h4000_0004, 32'hFFFF_FFFE);
    wr32(32'h4000_0008, 32'h0000_0003);
    rd32(32'h4000_0004);     chk(last_rd, 32'hFFFF_FFFE, "tl_start");
    rd32(32'h4000_0004);     chk(last_rd, 32'hFFFF_FFFF, "tl_max");
    chk({31'h0, irq}, 32'h1, "irq_on_wrap");
    rd32(32'h4000_0004);     chk(last_rd, 32'hFFFF_FFFD, "tl_reload");
    wr32(32'h4000_0008, 32'h0000_0003);
    chk({31'h0, irq}, 32'h0, "irq_cleared");
    wr32(32'h4000_0004, 32'h0000_0005);
    chk({31'h0, irq}, 32'h0, "tl_write_priority_irq");
    rd32(32'h4000_0004);     chk(last_rd, 32'h0000_0005, "tl_write_priority");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        a = 32'h4000_0000 | ($urandom & 32'h8000_0000) | ($urandom_range(0, 7) << 2);
        if ($urandom_range(0, 3) == 0) a = a | $urandom_range(1, 3);
      end else begin
        a = ($urandom & 32'hBFFF_F000) | $urandom_range(0, 63);
      end
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom);
    end

    wr32(32'h4000_0008, 32'h0);
    wr32(32'h4000_0000, 32'h0000_0010);
    wr32(32'h4000_0004, 32'hFFFF_FFFF);
    wr32(32'h4000_0008, 32'h0000_0003);
    wr32(32'h4000_0010, 32'h0000_0123);
    chk({31'h0, irq}, 32'h1, "irq_before_reset");
    #2 reset = 1'b1;
    #1;
    chk({31'h0, irq}, 32'h0, "midop_reset_irq");
    chk(32'(BCD_out), 32'h0, "midop_reset_bcd");
    chk(32'(LED_out), 32'h0, "midop_reset_led");
    m_reset();
    @(negedge clk);
    reset = 1'b0;
    rd32(32'h4000_0004);     chk(last_rd, 32'h0, "tl_after_reset");
    rd32(32'h4000_0008);     chk(last_rd, 32'h0, "tcon_after_reset");
    rd32(32'h0000_0008);     chk(last_rd, 32'h0000_005B, "seg_restored");
    rd32(32'h4000_0014);     chk(last_rd, 32'h0000_0003, "systick_count");
    chk({31'h0, irq}, 32'h0, "no_residual_irq");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
